// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port GPR file.
// Holds default geometry, sweep FSM states and the zero word.
package regfile_pkg;

    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam logic [RF_DW-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port of regfile_mp: gate, zero-reg and write bypass mux.
// Ports: run, re, raddr, both write ports, stored word in; rdata out.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          run,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  logic [DW-1:0] wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] stored,
    output logic [DW-1:0] rdata
);

    localparam logic [DW-1:0] ZW = DW'(ZERO_WORD);

    // Port 1 is the younger write, so it is checked first.
    always_comb begin
        rdata = ZW;
        if (!run || !re) begin
            rdata = ZW;
        end else if (ZERO_REG != 0 && raddr == '0) begin
            rdata = ZW;
        end else if (we1 && waddr1 == raddr) begin
            rdata = wdata1;
        end else if (we0 && waddr0 == raddr) begin
            rdata = wdata0;
        end else begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: N combinational read ports, two ordered writes.
// Ports: clk, rst, ready, we0/waddr0/wdata0, we1/waddr1/wdata1, re, raddr, rdata.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int RD_PORTS = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   we0,
    input  logic [AW-1:0]          waddr0,
    input  logic [DW-1:0]          wdata0,
    input  logic                   we1,
    input  logic [AW-1:0]          waddr1,
    input  logic [DW-1:0]          wdata1,
    input  logic [RD_PORTS-1:0]    re,
    input  logic [RD_PORTS*AW-1:0] raddr,
    output logic [RD_PORTS*DW-1:0] rdata
);

    rf_state_e     state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] mem [DEPTH];
    logic          wen0;
    logic          wen1;

    assign ready = (state == RF_RUN);

    // Address 0 is read-only when hard-wired to zero.
    assign wen0 = we0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign wen1 = we1 && !(ZERO_REG != 0 && waddr1 == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_INIT;
            cnt   <= '0;
        end else if (state == RF_INIT) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(DEPTH - 1)) begin
                state <= RF_RUN;
            end
        end
    end

    // Port 1 assigned last so it wins an address clash.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_INIT) begin
                mem[cnt] <= '0;
            end else begin
                if (wen0) begin
                    mem[waddr0] <= wdata0;
                end
                if (wen1) begin
                    mem[waddr1] <= wdata1;
                end
            end
        end
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        regfile_rd_port #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .run    (ready),
            .re     (re[i]),
            .raddr  (raddr[i*AW +: AW]),
            .we0    (we0),
            .waddr0 (waddr0),
            .wdata0 (wdata0),
            .we1    (we1),
            .waddr1 (waddr1),
            .wdata1 (wdata1),
            .stored (mem[raddr[i*AW +: AW]]),
            .rdata  (rdata[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (4 ports/zero reg, 2 ports/plain).
// Directed scenarios then random traffic against a behavioural model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NP    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready_a;
    logic             ready_b;
    logic             we0;
    logic [AW-1:0]    waddr0;
    logic [DW-1:0]    wdata0;
    logic             we1;
    logic [AW-1:0]    waddr1;
    logic [DW-1:0]    wdata1;
    logic [NP-1:0]    re;
    logic [NP*AW-1:0] raddr;
    logic [NP*DW-1:0] rdata_a;
    logic [2*DW-1:0]  rdata_b;

    int checks = 0;
    int errors = 0;

    // Model: array per instance, sweep progress and ready state.
    logic [DW-1:0] m_a [DEPTH];
    logic [DW-1:0] m_b [DEPTH];
    int            m_cnt = 0;
    bit            m_run = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(
        .DW(DW), .DEPTH(DEPTH), .RD_PORTS(NP), .ZERO_REG(1)
    ) dut_a (
        .clk(clk), .rst(rst), .ready(ready_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata_a)
    );

    regfile_mp #(
        .DW(DW), .DEPTH(DEPTH), .RD_PORTS(2), .ZERO_REG(0)
    ) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re[1:0]), .raddr(raddr[2*AW-1:0]), .rdata(rdata_b)
    );

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(bit zr, int p);
        logic [AW-1:0] a;
        a = raddr[p*AW +: AW];
        if (!m_run || !re[p]) return '0;
        if (zr && a == '0) return '0;
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
        return zr ? m_a[a] : m_b[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_cnt = 0;
            m_run = 1'b0;
        end else if (!m_run) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_run = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    m_a[i] = '0;
                    m_b[i] = '0;
                end
            end
        end else begin
            if (we0) m_b[waddr0] = wdata0;
            if (we1) m_b[waddr1] = wdata1;
            if (we0 && waddr0 != '0) m_a[waddr0] = wdata0;
            if (we1 && waddr1 != '0) m_a[waddr1] = wdata1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_all();
        #1;
        chk("ready_a", DW'(ready_a), DW'(m_run));
        chk("ready_b", DW'(ready_b), DW'(m_run));
        for (int p = 0; p < NP; p++)
            chk($sformatf("rd_a[%0d]", p), rdata_a[p*DW +: DW], exp_rd(1'b1, p));
        for (int p = 0; p < 2; p++)
            chk($sformatf("rd_b[%0d]", p), rdata_b[p*DW +: DW], exp_rd(1'b0, p));
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        re = '0; raddr = '0;
    endtask

    task automatic rand_in();
        we0    = 1'($urandom);
        we1    = 1'($urandom);
        waddr0 = AW'($urandom_range(0, 7));
        waddr1 = AW'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) waddr1 = AW'($urandom);
        wdata0 = $urandom;
        wdata1 = $urandom;
        re     = NP'($urandom);
        for (int p = 0; p < NP; p++)
            raddr[p*AW +: AW] = AW'($urandom_range(0, 7));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        tick();
        tick();
        check_all();
        chk("reset_ready", DW'(ready_a), '0);

        // Sweep after a single release: 32 cycles not ready.
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            rand_in();
            check_all();
            chk("sweep_ready", DW'(ready_a), '0);
            tick();
        end
        idle();
        check_all();
        chk("ready_after_sweep", DW'(ready_a), 32'd1);

        re = '1;
        for (int k = 0; k < DEPTH / NP; k++) begin
            for (int p = 0; p < NP; p++)
                raddr[p*AW +: AW] = AW'(k * NP + p);
            check_all();
            chk("cleared", rdata_a[(NP-1)*DW +: DW], '0);
            tick();
        end

        // Reset mid-sweep restarts the full sweep.
        idle();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hCAFEF00D;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_all();
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        re = 4'b0001; raddr[0 +: AW] = 5'd3;
        for (int k = 0; k < DEPTH; k++) begin
            check_all();
            chk("resweep_ready", DW'(ready_a), '0);
            tick();
        end
        check_all();
        chk("ready_after_resweep", DW'(ready_a), 32'd1);
        chk("reg3_cleared", rdata_a[0 +: DW], '0);

        // Clash on address 5: port 1 wins, bypass and storage.
        idle();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h12345678;
        re = 4'b0001; raddr[0 +: AW] = 5'd5;
        check_all();
        chk("clash_bypass", rdata_a[0 +: DW], 32'h12345678);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        check_all();
        chk("clash_stored", rdata_a[0 +: DW], 32'h12345678);
        tick();

        // Read enable gates the bypass per port.
        idle();
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hA5A5A5A5;
        re = 4'b0001;
        raddr[0 +: AW] = 5'd7; raddr[AW +: AW] = 5'd7;
        check_all();
        chk("re_on", rdata_a[0 +: DW], 32'hA5A5A5A5);
        chk("re_off", rdata_a[DW +: DW], '0);
        tick();

        // Address 0: hard-wired zero vs plain register.
        idle();
        we0 = 1'b1; waddr0 = '0; wdata0 = 32'hFFFFFFFF;
        re = '1;
        check_all();
        chk("zr_bypass", rdata_a[0 +: DW], '0);
        chk("nz_bypass", rdata_b[0 +: DW], 32'hFFFFFFFF);
        tick();
        we0 = 1'b0;
        check_all();
        chk("zr_stored", rdata_a[0 +: DW], '0);
        chk("nz_stored", rdata_b[0 +: DW], 32'hFFFFFFFF);
        tick();

        // Four ports read four fresh registers at once.
        idle();
        we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h22;
        tick();
        waddr0 = 5'd3; wdata0 = 32'h33;
        waddr1 = 5'd4; wdata1 = 32'h44;
        tick();
        idle();
        re = '1;
        for (int p = 0; p < NP; p++)
            raddr[p*AW +: AW] = AW'(p + 1);
        check_all();
        for (int p = 0; p < NP; p++)
            chk($sformatf("quad[%0d]", p), rdata_a[p*DW +: DW], DW'(32'h11 * (p + 1)));
        tick();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            rand_in();
            check_all();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
